// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with a 2-bit saturating-counter BHT and one-cycle registered result.
// Define BR_STATS_EN to compile in the branch/mispredict statistics counters; otherwise stat_* read as zero.
module branch_resolve_unit #(
    parameter int          XLEN     = 32,
    parameter int          BHT_IDX  = 6,
    parameter logic [1:0]  BHT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,

    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_reg1,
    input  logic [XLEN-1:0] ex_reg2,
    input  logic [2:0]      ex_br_type,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_br_target,
    input  logic            ex_predict_taken,
    input  logic            flush,

    output logic            res_valid,
    output logic            res_is_branch,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic [XLEN-1:0] res_target,

    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    // Branch-type codes shared with the rest of the pipeline.
    localparam logic [2:0] BR_NOBRANCH = 3'd0;
    localparam logic [2:0] BR_BEQ      = 3'd1;
    localparam logic [2:0] BR_BNE      = 3'd2;
    localparam logic [2:0] BR_BLT      = 3'd3;
    localparam logic [2:0] BR_BLTU     = 3'd4;
    localparam logic [2:0] BR_BGE      = 3'd5;
    localparam logic [2:0] BR_BGEU     = 3'd6;

    localparam int BHT_N = 1 << BHT_IDX;

    // ------------------------------------------------------------------
    // Compare and decode
    // ------------------------------------------------------------------
    logic            cmp_eq;
    logic            cmp_lt_s;
    logic            cmp_lt_u;
    logic            is_branch;
    logic            taken;
    logic            accept;
    logic            mispredict;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_target;

    assign cmp_eq   = (ex_reg1 == ex_reg2);
    assign cmp_lt_s = ($signed(ex_reg1) < $signed(ex_reg2));
    assign cmp_lt_u = (ex_reg1 < ex_reg2);
    assign pc_plus4 = ex_pc + XLEN'(4);

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (ex_br_type)
            BR_BEQ:  begin is_branch = 1'b1; taken = cmp_eq;    end
            BR_BNE:  begin is_branch = 1'b1; taken = !cmp_eq;   end
            BR_BLT:  begin is_branch = 1'b1; taken = cmp_lt_s;  end
            BR_BGE:  begin is_branch = 1'b1; taken = !cmp_lt_s; end
            BR_BLTU: begin is_branch = 1'b1; taken = cmp_lt_u;  end
            BR_BGEU: begin is_branch = 1'b1; taken = !cmp_lt_u; end
            BR_NOBRANCH: begin is_branch = 1'b0; taken = 1'b0;  end
            default: begin is_branch = 1'b0; taken = 1'b0;      end
        endcase
    end

    assign accept      = ex_valid && !flush;
    assign mispredict  = is_branch && (taken ^ ex_predict_taken);
    assign next_target = taken ? ex_br_target : pc_plus4;

    // ------------------------------------------------------------------
    // Registered resolution result; all fields zero when not valid
    // ------------------------------------------------------------------
    logic            res_valid_q,      res_valid_d;
    logic            res_is_branch_q,  res_is_branch_d;
    logic            res_taken_q,      res_taken_d;
    logic            res_mispredict_q, res_mispredict_d;
    logic [XLEN-1:0] res_target_q,     res_target_d;

    always_comb begin
        res_valid_d      = 1'b0;
        res_is_branch_d  = 1'b0;
        res_taken_d      = 1'b0;
        res_mispredict_d = 1'b0;
        res_target_d     = '0;
        if (accept) begin
            res_valid_d      = 1'b1;
            res_is_branch_d  = is_branch;
            res_taken_d      = taken;
            res_mispredict_d = mispredict;
            res_target_d     = next_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q      <= 1'b0;
            res_is_branch_q  <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            res_target_q     <= '0;
        end else begin
            res_valid_q      <= res_valid_d;
            res_is_branch_q  <= res_is_branch_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            res_target_q     <= res_target_d;
        end
    end

    assign res_valid      = res_valid_q;
    assign res_is_branch  = res_is_branch_q;
    assign res_taken      = res_taken_q;
    assign res_mispredict = res_mispredict_q;
    assign res_target     = res_target_q;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]         bht_q [BHT_N];
    logic [BHT_IDX-1:0] lookup_idx;
    logic [BHT_IDX-1:0] ex_idx;
    logic [1:0]         ctr_cur;
    logic [1:0]         ctr_d;
    logic               bht_upd;

    assign lookup_idx = lookup_pc[BHT_IDX+1:2];
    assign ex_idx     = ex_pc[BHT_IDX+1:2];
    assign bht_upd    = accept && is_branch;
    assign ctr_cur    = bht_q[ex_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= BHT_INIT;
            end
        end else if (bht_upd) begin
            bht_q[ex_idx] <= ctr_d;
        end
    end

    // Read straight from the array: a same-cycle update is not forwarded.
    assign lookup_taken = bht_q[lookup_idx][1];

    // PC bits outside the index field do not participate in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:BHT_IDX+2], lookup_pc[1:0],
                              ex_pc[XLEN-1:BHT_IDX+2], ex_pc[1:0]};

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BR_STATS_EN
    logic [31:0] stat_br_q,  stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (bht_upd) begin
            if (stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
            if (mispredict && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand/PC/target width.
REQ-002 The module SHALL have parameter BHT_IDX, default 6, meaning log2 of branch-history-table entries (64).
REQ-003 The module SHALL have parameter BHT_INIT, default 2'b01, meaning counter reset value (weakly not-taken).
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 lookup_pc  input  XLEN  fetch-stage PC for prediction.
REQ-008 lookup_taken  output  1  prediction for lookup_pc, combinational.
REQ-009 ex_valid  input  1  execute-stage operands valid this cycle.
REQ-010 ex_reg1, ex_reg2  input  XLEN  compare operands.
REQ-011 ex_br_type  input  3  branch type, encoded with the NOBRANCH/BEQ/BNE/BLT/BGE/BLTU/BGEU macros of Parameters.v.
REQ-012 ex_pc, ex_br_target  input  XLEN  branch PC and computed taken-target.
REQ-013 ex_predict_taken  input  1  prediction carried down the pipe.
REQ-014 flush  input  1  kill the execute-stage instruction this cycle.
REQ-015 res_valid, res_is_branch, res_taken, res_mispredict  output  1  registered resolution result.
REQ-016 res_target  output  XLEN  registered redirect/next PC.
REQ-017 stat_branches, stat_mispredicts  output  32  statistics counters.

Function
REQ-018 Latency SHALL be one cycle: inputs sampled at rising edge N, res_* valid after edge N until edge N+1.
REQ-019 res_valid SHALL equal ex_valid & ~flush registered; when res_valid=0 all other res_* SHALL be 0.
REQ-020 BEQ/BNE equality, BLTU/BGEU unsigned, BLT/BGE two's-complement signed compare over all XLEN bits.
REQ-021 NOBRANCH and undefined ex_br_type codes SHALL give is_branch=0, taken=0.
REQ-022 res_mispredict SHALL be is_branch & (taken ^ ex_predict_taken); non-branches never mispredict.
REQ-023 res_target SHALL be ex_br_target if taken, else ex_pc+4 modulo 2^XLEN (wraps at all-ones).
REQ-024 BHT SHALL hold 2^BHT_IDX 2-bit saturating counters indexed by pc[BHT_IDX+1:2].
REQ-025 lookup_taken SHALL be bit 1 of the counter indexed by lookup_pc.
REQ-026 On an edge with ex_valid & ~flush & is_branch, the counter at ex_pc index SHALL increment if taken (saturate 3), else decrement (saturate 0).
REQ-027 No other condition SHALL modify the BHT; flush suppresses the update.
REQ-028 Same-cycle lookup and update of one entry SHALL return the pre-update value (no bypass).

Reset
REQ-029 rst_n low SHALL immediately clear all res_* to 0, set every BHT counter to BHT_INIT, and clear statistics counters.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight result; first result follows the first edge after release.

Configuration
REQ-031 Macro BR_STATS_EN SHALL compile in statistics: stat_branches counts resolved branches (REQ-026 condition), stat_mispredicts counts those with mispredict; both saturate at 32'hFFFFFFFF.
REQ-032 Without BR_STATS_EN, stat_* ports SHALL remain present and be tied to 0, with no counter logic.

Verification
REQ-033 BLT reg1=32'hFFFFFFFF, reg2=1, predict=0, pc=0x100, target=0x80 -> next cycle res_taken=1, res_mispredict=1, res_target=0x80.
REQ-034 BGEU reg1=1, reg2=32'hFFFFFFFF, pc=32'hFFFFFFFC -> res_taken=0, res_target=0 (wrap).
REQ-035 Three taken BEQ at pc=0x40 after reset -> counter 01->10->11->11; lookup_pc=0x40 yields 0 then 1 from the first update on.
REQ-036 ex_valid=1, flush=1, taken BNE -> res_valid=0, BHT entry unchanged, stats unchanged.
REQ-037 NOBRANCH with ex_predict_taken=1 -> res_is_branch=0, res_mispredict=0, res_target=pc+4.
REQ-038 With BR_STATS_EN, 5 branches incl. 2 mispredicts -> stat_branches=5, stat_mispredicts=2; rst_n low mid-run clears both asynchronously.
